// File: rtl/nibble_loop_seq_pkg.sv
// rtl/nibble_loop_seq_pkg.sv - shared ALU command/control types and sequencer state encoding
package nibble_loop_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    CMD_ADD   = 3'd0,
    CMD_SUB   = 3'd1,
    CMD_AND   = 3'd2,
    CMD_OR    = 3'd3,
    CMD_XOR   = 3'd4,
    CMD_LSHFT = 3'd5,
    CMD_RSHFT = 3'd6,
    CMD_PASS  = 3'd7
  } AluCmd;

  typedef struct packed {
    AluCmd             cmd;
    logic [WORD_W-1:0] word1;
    logic [WORD_W-1:0] word2;
    logic [WORD_W-1:0] preinit;
    logic              one_nibble;
  } AluCtrl;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_ARM  = 3'd2,
    ST_RUN  = 3'd3,
    ST_FIN  = 3'd4,
    ST_CAPT = 3'd5,
    ST_RESP = 3'd6
  } nibble_seq_state_t;

endpackage

// File: rtl/nibble_loop_seq_if.sv
// rtl/nibble_loop_seq_if.sv - request/response handshake bundle between a client and the sequencer
interface nibble_loop_seq_if;
  import nibble_loop_seq_pkg::*;

  logic              req_valid;
  logic              req_ready;
  AluCmd             req_cmd;
  logic [WORD_W-1:0] req_w1;
  logic [WORD_W-1:0] req_w2;
  logic [WORD_W-1:0] req_preinit;
  logic              req_one_nibble;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_result;
  logic              rsp_err;

  modport master (
    output req_valid, req_cmd, req_w1, req_w2, req_preinit, req_one_nibble, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_err
  );

  modport slave (
    input  req_valid, req_cmd, req_w1, req_w2, req_preinit, req_one_nibble, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_err
  );

endinterface

// File: rtl/nibble_loop_seq.sv
// rtl/nibble_loop_seq.sv - single-op sequencer driving a nibble-serial ALU loop
// Optional watchdog abort of a stuck RUN phase: NIBBLE_LOOP_SEQ_WDOG_EN.
module nibble_loop_seq
  import nibble_loop_seq_pkg::*;
#(
  parameter int WDOG_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  nibble_loop_seq_if.slave  bus,
  output logic              loop_perm_to_count,
  output logic              loop_over_one_nibble,
  output AluCmd             loop_cmd,
  output logic [WORD_W-1:0] loop_word1,
  output logic [WORD_W-1:0] loop_word2,
  output logic [WORD_W-1:0] loop_preinit,
  input  logic              loop_busy,
  input  logic [WORD_W-1:0] loop_result
);

  nibble_seq_state_t state;
  AluCtrl            hold;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_result_q;
  logic              perm_q;

  assign bus.req_ready  = req_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;

  // Loop operands come straight from the hold registers, which only change on accept.
  assign loop_perm_to_count   = perm_q;
  assign loop_over_one_nibble = hold.one_nibble;
  assign loop_cmd             = hold.cmd;
  assign loop_word1           = hold.word1;
  assign loop_word2           = hold.word2;
  assign loop_preinit         = hold.preinit;

`ifdef NIBBLE_LOOP_SEQ_WDOG_EN
  localparam int CNT_W = $clog2(WDOG_CYCLES + 1);

  logic [CNT_W-1:0] wdog_cnt;
  logic             wdog_abort;
  logic             rsp_err_q;

  assign bus.rsp_err = rsp_err_q;
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;

  assign bus.rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      hold         <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      perm_q       <= 1'b0;
`ifdef NIBBLE_LOOP_SEQ_WDOG_EN
      wdog_cnt     <= '0;
      wdog_abort   <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            hold <= '{cmd:        bus.req_cmd,
                      word1:      bus.req_w1,
                      word2:      bus.req_w2,
                      preinit:    bus.req_preinit,
                      one_nibble: bus.req_one_nibble};
            req_ready_q <= 1'b0;
            state       <= ST_PRE;
          end
        end
        ST_PRE: begin
          perm_q <= 1'b1;
          state  <= ST_ARM;
        end
        ST_ARM: begin
          state <= ST_RUN;
        end
        ST_RUN: begin
`ifdef NIBBLE_LOOP_SEQ_WDOG_EN
          if (!loop_busy) begin
            wdog_cnt <= '0;
            state    <= ST_FIN;
          end else if (wdog_cnt == CNT_W'(WDOG_CYCLES - 1)) begin
            // Abort skips FIN: permission drops as the partial result is captured.
            wdog_cnt   <= '0;
            wdog_abort <= 1'b1;
            perm_q     <= 1'b0;
            state      <= ST_CAPT;
          end else begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
          end
`else
          if (!loop_busy) begin
            state <= ST_FIN;
          end
`endif
        end
        ST_FIN: begin
          perm_q <= 1'b0;
          state  <= ST_CAPT;
        end
        ST_CAPT: begin
          rsp_result_q <= loop_result;
          rsp_valid_q  <= 1'b1;
`ifdef NIBBLE_LOOP_SEQ_WDOG_EN
          rsp_err_q    <= wdog_abort;
          wdog_abort   <= 1'b0;
`endif
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
`ifdef NIBBLE_LOOP_SEQ_WDOG_EN
            rsp_err_q   <= 1'b0;
`endif
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_loop_seq.sv
// tb/tb_nibble_loop_seq.sv - self-checking bench for nibble_loop_seq with a behavioural nibble loop
module tb_nibble_loop_seq;
  import nibble_loop_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        loop_perm_to_count;
  logic        loop_over_one_nibble;
  AluCmd       loop_cmd;
  logic [31:0] loop_word1;
  logic [31:0] loop_word2;
  logic [31:0] loop_preinit;
  logic        loop_busy;
  logic [31:0] loop_result;

  nibble_loop_seq_if bus();

  nibble_loop_seq #(.WDOG_CYCLES(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .bus                  (bus),
    .loop_perm_to_count   (loop_perm_to_count),
    .loop_over_one_nibble (loop_over_one_nibble),
    .loop_cmd             (loop_cmd),
    .loop_word1           (loop_word1),
    .loop_word2           (loop_word2),
    .loop_preinit         (loop_preinit),
    .loop_busy            (loop_busy),
    .loop_result          (loop_result)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int plan_busy = 1;
  int busy_left = 0;

`ifdef NIBBLE_LOOP_SEQ_WDOG_EN
  localparam int MAX_BUSY = 4;
`else
  localparam int MAX_BUSY = 8;
`endif

  function automatic logic [31:0] alu_ref(AluCmd c, logic [31:0] a, logic [31:0] b, logic [31:0] p);
    case (c)
      CMD_ADD:   return a + b;
      CMD_SUB:   return a - b;
      CMD_AND:   return a & b;
      CMD_OR:    return a | b;
      CMD_XOR:   return a ^ b;
      CMD_LSHFT: return b << 1;
      CMD_RSHFT: return b >> 1;
      default:   return p;
    endcase
  endfunction

  // Downstream loop: busy for plan_busy cycles (one cycle for a single nibble) once permitted.
  always @(posedge clk) begin
    if (!loop_perm_to_count)
      busy_left <= loop_over_one_nibble ? 1 : plan_busy;
    else if (busy_left != 0)
      busy_left <= busy_left - 1;
  end
  assign loop_busy   = (busy_left != 0);
  assign loop_result = alu_ref(loop_cmd, loop_word1, loop_word2, loop_preinit);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Issue one request and wait for rsp_valid; lat counts edges from the accept edge.
  task automatic do_op(input AluCmd c, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic one, input int busy,
                       output logic [31:0] res, output logic err, output int lat,
                       output int perm_cnt);
    int  w;
    bit  ok;
    bit  seen;
    @(negedge clk);
    plan_busy = busy;
    bus.req_cmd = c;
    bus.req_w1 = a;
    bus.req_w2 = b;
    bus.req_preinit = p;
    bus.req_one_nibble = one;
    bus.req_valid = 1'b1;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = 1;
    perm_cnt = 0;
    ok = 0;
    seen = 0;
    res = '0;
    err = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (loop_perm_to_count) begin
        perm_cnt++;
        if (!seen) begin
          seen = 1;
          check("loop_operands", {loop_word1, loop_word2}, {a, b});
          check("loop_cmd_preinit", {29'd0, loop_cmd, loop_preinit}, {29'd0, c, p});
        end
      end
      if (bus.rsp_valid) begin
        ok = 1;
        res = bus.rsp_result;
        err = bus.rsp_err;
        break;
      end
      lat++;
    end
    check("rsp_within_bound", 64'(ok), 64'd1);
  endtask

  typedef struct {
    AluCmd       cmd;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] pre;
    logic        one;
    int          busy;
    logic [31:0] exp_res;
    int          exp_n;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] res;
  logic [31:0] r0;
  logic        err;
  int          lat;
  int          perm_cnt;
  int          bad;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{CMD_ADD,   32'h0EFF_FFFF, 32'h0000_0001, 32'hF000_0000, 1'b0, 3, 32'h0F00_0000, 3};
    vecs[1] = '{CMD_ADD,   32'hFFFF_0FFF, 32'h0000_0002, 32'h0000_0000, 1'b0, 4, 32'hFFFF_1001, 4};
    vecs[2] = '{CMD_RSHFT, 32'h0000_0000, 32'h0600_0000, 32'h0000_0000, 1'b0, 2, 32'h0300_0000, 2};
    vecs[3] = '{CMD_XOR,   32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0000_0000, 1'b0, 1, 32'h0F0F_F0F0, 1};
    vecs[4] = '{CMD_SUB,   32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 1'b1, 3, 32'hFFFF_FFFE, 1};
    vecs[5] = '{CMD_PASS,  32'h1234_5678, 32'h9ABC_DEF0, 32'hA5A5_A5A5, 1'b0, 2, 32'hA5A5_A5A5, 2};

    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_cmd = CMD_ADD;
    bus.req_w1 = '0;
    bus.req_w2 = '0;
    bus.req_preinit = '0;
    bus.req_one_nibble = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_req_ready", 64'(bus.req_ready), 64'd1);
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset_rsp_result_err", {31'd0, bus.rsp_err, bus.rsp_result}, 64'd0);
    check("reset_perm", 64'(loop_perm_to_count), 64'd0);
    check("reset_hold", {loop_word1, loop_word2 | loop_preinit}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].cmd, vecs[i].w1, vecs[i].w2, vecs[i].pre, vecs[i].one, vecs[i].busy,
            res, err, lat, perm_cnt);
      check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].exp_res));
      check($sformatf("vec%0d_err", i), 64'(err), 64'd0);
      check($sformatf("vec%0d_run_cycles", i), 64'(perm_cnt - 2), 64'(vecs[i].exp_n));
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(5 + perm_cnt - 2));
      @(negedge clk);
      check($sformatf("vec%0d_back_idle", i), {62'd0, bus.rsp_valid, bus.req_ready}, 64'd1);
    end

    // Response back-pressure, with a request offered during RESP that must be ignored.
    bus.rsp_ready = 1'b0;
    do_op(CMD_OR, 32'h00FF_0000, 32'h0000_00FF, 32'h0, 1'b0, 2, res, err, lat, perm_cnt);
    check("stall_result", 64'(res), 64'h00FF_00FF);
    r0 = res;
    bus.req_cmd = CMD_AND;
    bus.req_w1 = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("stall%0d_result", k), 64'(bus.rsp_result), 64'(r0));
      check($sformatf("stall%0d_req_ready", k), 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("release_idle", {61'd0, bus.rsp_valid, bus.req_ready, loop_perm_to_count}, 64'd2);
    check("release_no_accept_hold", 64'(loop_word1), 64'h00FF_0000);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("release_still_idle", 64'(bus.req_ready), 64'd1);

    // Reset during RUN discards the operation.
    plan_busy = 6;
    bus.req_cmd = CMD_ADD;
    bus.req_w1 = 32'h1;
    bus.req_w2 = 32'h2;
    bus.req_one_nibble = 1'b0;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    bad = 0;
    for (int k = 0; k < 20 && bad < 3; k++) begin
      @(negedge clk);
      if (loop_perm_to_count) bad++;
    end
    check("reached_run", 64'(bad), 64'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_run_perm", 64'(loop_perm_to_count), 64'd0);
    check("rst_run_ready_valid", {62'd0, bus.req_ready, bus.rsp_valid}, 64'd2);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    check("rst_run_no_response", 64'(bad), 64'd0);
    do_op(CMD_ADD, 32'h1234_5678, 32'h1111_1111, 32'h0, 1'b0, 3, res, err, lat, perm_cnt);
    check("post_rst_result", 64'(res), 64'h2345_6789);
    check("post_rst_latency", 64'(lat), 64'(5 + 3));

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      AluCmd       c;
      logic [31:0] a, b, p;
      logic        one;
      int          busy;
      int          n;
      c = AluCmd'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      p = $urandom;
      one = 1'($urandom_range(0, 1));
      busy = $urandom_range(1, MAX_BUSY);
      n = one ? 1 : busy;
      do_op(c, a, b, p, one, busy, res, err, lat, perm_cnt);
      check($sformatf("rand%0d_result", i), 64'(res), 64'(alu_ref(c, a, b, p)));
      check($sformatf("rand%0d_timing", i), {32'(lat), 31'd0, err}, {32'(5 + n), 32'd0});
    end

`ifdef NIBBLE_LOOP_SEQ_WDOG_EN
    do_op(CMD_ADD, 32'h0000_0010, 32'h0000_0020, 32'h0, 1'b0, 1000, res, err, lat, perm_cnt);
    check("wdog_err", 64'(err), 64'd1);
    check("wdog_result", 64'(res), 64'h0000_0030);
    check("wdog_run_cycles", 64'(perm_cnt - 1), 64'd4);
    check("wdog_latency", 64'(lat), 64'd8);
    @(negedge clk);
    check("wdog_cleared", {62'd0, bus.rsp_valid, bus.rsp_err}, 64'd0);
    plan_busy = 1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
